cache_fill_arbiter: RTL and testbench
=====================================

Name: cache_fill_arbiter

Overview:
- Shares the single-port, pipelined main memory between I-cache miss fills, D-cache miss fills and D-cache write-through stores.
- Sequences each 8-word (16-byte) block fill: issues word addresses, steers returned data into the correct cache's data array, then writes the metadata (tag/valid).
- Drives the global pipeline stall.
- Sits between the two cache arrays and the memory model.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 16, data word width in bits.
- WORDS, 8, words per block; the offset width is log2(WORDS).
- MEM_LAT, 4, memory read latency in cycles from mem_en to mem_vld. Informational only; the block counts mem_vld pulses.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_miss  in  1  I-cache miss, level; held until serviced.
- i_addr  in  ADDR_W  I-cache miss address.
- d_miss  in  1  D-cache miss, level.
- d_addr  in  ADDR_W  D-cache miss or write address.
- d_wr  in  1  D-cache write-through request, level.
- d_wdata  in  DATA_W  store data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_vld  in  1  read data valid.
- fill_data  out  DATA_W  data to the cache data array (equals mem_rdata).
- fill_word  out  3  word index within the block for the current write.
- i_data_we  out  1  I-cache data-array write enable.
- i_meta_we  out  1  I-cache metadata write enable.
- d_data_we  out  1  D-cache data-array write enable.
- d_meta_we  out  1  D-cache metadata write enable.
- stall  out  1  pipeline stall.

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - state=IDLE.
  - All counters and latched address/target cleared.
  - All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, every *_we, fill_word. stall follows its combinational equation.
- States: IDLE, WRITE, FILL, DONE.
- IDLE:
  - Grant priority is d_wr > d_miss > i_miss.
  - Grant d_wr → WRITE.
  - Grant a miss → FILL. On the grant edge, latch base={addr[15:4],4'h0} and target (I or D). Clear issue_cnt and ret_cnt.
- WRITE (1 cycle):
  - mem_en=1, mem_we=1, mem_addr=d_addr, mem_wdata=d_wdata.
  - Next state IDLE.
  - A d_wr still high in the following cycle is a new store.
- FILL:
  - While issue_cnt<WORDS: mem_en=1, mem_we=0, mem_addr=base+2*issue_cnt; issue_cnt increments each cycle.
  - Low 4 address bits wrap within the block; the upper bits never change.
  - On each cycle with mem_vld=1:
    - Assert target data_we.
    - fill_word=ret_cnt (offset-adjusted, see Optional Feature).
    - fill_data=mem_rdata.
    - ret_cnt increments.
  - On the 8th return: assert target meta_we in the same cycle; next state DONE.
- DONE (1 cycle):
  - Gives the cache a tag-lookup cycle, so the served miss deasserts before the next grant.
  - No memory access.
  - Next state IDLE.
- Latency: fill completion = WORDS+MEM_LAT cycles from grant (12 at defaults, last return), +1 DONE cycle.
- mem_vld handling:
  - mem_vld outside FILL is ignored (no writes).
  - mem_vld may arrive during issue; data and issue overlap.
- stall equation:
  - (state==FILL) | (state==DONE) | i_miss | d_miss.
  - Plus d_wr, except in the WRITE cycle, where the store completes and stall=0 unless a miss is pending.
- Simultaneous i_miss and d_miss: D is served first, I is served after DONE→IDLE. stall stays high throughout.
- d_wr arriving during a fill: waits. stall=1; the write is serviced on the next IDLE grant.
- Requester inputs changing during FILL have no effect; base and target are latched.
- Reset mid-fill: state returns to IDLE next edge and all counters clear. The memory shares rst, so no stale mem_vld may arrive afterward.

Optional Feature:
- Macro: CRIT_WORD_FIRST_EN.
- Defined:
  - Latch start=addr[3:1] at grant.
  - Issue mem_addr=base+2*((start+issue_cnt) mod 8).
  - fill_word=(start+ret_cnt) mod 8.
  - The missed word returns first.
- Undefined:
  - start is treated as 0.
  - Words are filled 0..7 in order.
  - The start field is not implemented.

Test Plan:
- Reset: rst=1 for 2 cycles with i_miss=1 → all mem/we outputs 0, state IDLE. After release, FILL begins on the first edge.
- I miss alone, i_addr=0x1236, MEM_LAT=4:
  - mem_addr sequence 0x1230,0x1232,…,0x123E over 8 cycles.
  - 8 i_data_we pulses with fill_word 0..7.
  - i_meta_we together with the 8th pulse; d_* stay 0.
  - stall high until the cycle after DONE.
- i_miss and d_miss together (d_addr=0x4008, i_addr=0x0100):
  - First fill uses 0x4000–0x400E with d_* enables.
  - Then 0x0100–0x010E with i_* enables.
  - No gap other than DONE+IDLE.
- d_wr=1 (d_addr=0x2002, d_wdata=0xBEEF) during an I fill:
  - stall stays 1.
  - After the fill: one WRITE cycle with mem_we=1, mem_addr=0x2002, mem_wdata=0xBEEF, stall=0.
- Reset asserted at the 5th issue cycle of a D fill:
  - Next cycle IDLE, no further mem_en, no d_meta_we.
  - A re-issued d_miss restarts from word 0.
- With CRIT_WORD_FIRST_EN defined, i_addr=0x123A:
  - mem_addr order 0x123A,0x123C,0x123E,0x1230,…,0x1238.
  - fill_word order 5,6,7,0,…,4.
  - i_meta_we on the 8th return.

Source files
------------

// File: rtl/cache_fill_arbiter.sv
// Memory arbiter for I/D cache block fills and D-cache write-through stores.
// Optional macro CRIT_WORD_FIRST_EN: fill starts at the missed word and wraps within the block.
module cache_fill_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int WORDS   = 8,
    parameter int MEM_LAT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_miss,
    input  logic [ADDR_W-1:0]          i_addr,
    input  logic                       d_miss,
    input  logic [ADDR_W-1:0]          d_addr,
    input  logic                       d_wr,
    input  logic [DATA_W-1:0]          d_wdata,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       mem_vld,
    output logic [DATA_W-1:0]          fill_data,
    output logic [$clog2(WORDS)-1:0]   fill_word,
    output logic                       i_data_we,
    output logic                       i_meta_we,
    output logic                       d_data_we,
    output logic                       d_meta_we,
    output logic                       stall
);

    localparam int OFF_W  = $clog2(WORDS);
    localparam int BYTE_W = $clog2(DATA_W / 8);
    localparam int LO_W   = OFF_W + BYTE_W;
    localparam int CNT_W  = OFF_W + 1;
    localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FILL,
        DONE
    } state_t;

    state_t                   state;
    logic [ADDR_W-LO_W-1:0]   blk;
    logic                     tgt_d;
    logic [CNT_W-1:0]         issue_cnt;
    logic [CNT_W-1:0]         ret_cnt;

    // Miss arbitration: a pending store blocks both misses; D beats I.
    logic                     grant_miss;
    logic [ADDR_W-1:0]        miss_addr;

    assign miss_addr  = d_miss ? d_addr : i_addr;
    assign grant_miss = (state == IDLE) && !d_wr && (d_miss || i_miss);

`ifdef CRIT_WORD_FIRST_EN
    logic [OFF_W-1:0] start;
    logic [OFF_W-1:0] start_next;
    logic             unused_bits;

    assign start_next  = miss_addr[LO_W-1:BYTE_W];
    assign unused_bits = &{1'b0, miss_addr[BYTE_W-1:0], (MEM_LAT > 0)};

    always_ff @(posedge clk) begin
        if (rst) begin
            start <= '0;
        end else if (grant_miss) begin
            start <= start_next;
        end
    end
`else
    logic [OFF_W-1:0] start;
    logic [OFF_W-1:0] start_next;
    logic             unused_bits;

    assign start       = '0;
    assign start_next  = '0;
    assign unused_bits = &{1'b0, miss_addr[LO_W-1:0], (MEM_LAT > 0)};
`endif

    logic [OFF_W-1:0] issue_word;
    assign issue_word = start + issue_cnt[OFF_W-1:0];

    // NOTE: mem_* are registered, so the grant edge already launches word 0 and
    // issue_cnt then counts words launched (starts at 1) rather than words pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            blk       <= '0;
            tgt_d     <= 1'b0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            case (state)
                IDLE: begin
                    if (d_wr) begin
                        state     <= WRITE;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end else if (grant_miss) begin
                        state     <= FILL;
                        blk       <= miss_addr[ADDR_W-1:LO_W];
                        tgt_d     <= d_miss;
                        issue_cnt <= CNT_W'(1);
                        ret_cnt   <= '0;
                        mem_en    <= 1'b1;
                        mem_addr  <= {miss_addr[ADDR_W-1:LO_W], start_next, {BYTE_W{1'b0}}};
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                FILL: begin
                    if (issue_cnt < WORDS_C) begin
                        mem_en    <= 1'b1;
                        mem_addr  <= {blk, issue_word, {BYTE_W{1'b0}}};
                        issue_cnt <= issue_cnt + 1'b1;
                    end
                    if (mem_vld) begin
                        ret_cnt <= ret_cnt + 1'b1;
                        if (ret_cnt == LAST_C) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // NOTE: array writes must land in the same cycle as mem_vld, so the fill side
    // is decoded from registered state rather than registered itself.
    logic fill_vld;
    logic last_ret;

    assign fill_vld  = (state == FILL) && mem_vld;
    assign last_ret  = fill_vld && (ret_cnt == LAST_C);
    assign fill_data = mem_rdata;
    assign fill_word = fill_vld ? (start + ret_cnt[OFF_W-1:0]) : '0;
    assign i_data_we = fill_vld && !tgt_d;
    assign d_data_we = fill_vld && tgt_d;
    assign i_meta_we = last_ret && !tgt_d;
    assign d_meta_we = last_ret && tgt_d;

    assign stall = (state == FILL) || (state == DONE) || i_miss || d_miss
                 || (d_wr && (state != WRITE));

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Randomized self-checking bench for cache_fill_arbiter against a pipelined memory model.
module tb_cache_fill_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int WORDS   = 8;
    localparam int MEM_LAT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_miss, d_miss, d_wr;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              mem_en, mem_we, mem_vld;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata, fill_data;
    logic [2:0]        fill_word;
    logic              i_data_we, i_meta_we, d_data_we, d_meta_we, stall;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cache_fill_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_addr(i_addr),
        .d_miss(d_miss), .d_addr(d_addr), .d_wr(d_wr), .d_wdata(d_wdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_vld(mem_vld),
        .fill_data(fill_data), .fill_word(fill_word),
        .i_data_we(i_data_we), .i_meta_we(i_meta_we),
        .d_data_we(d_data_we), .d_meta_we(d_meta_we),
        .stall(stall)
    );

    // Memory: read data is a seeded hash of the address, returned MEM_LAT cycles after the request.
    logic [15:0]        mem_seed;
    logic               force_vld;
    logic [MEM_LAT-1:0] vld_pipe;
    logic [15:0]        addr_pipe [MEM_LAT];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ mem_seed;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe     <= {vld_pipe[MEM_LAT-2:0], mem_en & ~mem_we};
            addr_pipe[0] <= mem_addr;
            for (int i = 1; i < MEM_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
        end
    end

    assign mem_vld   = vld_pipe[MEM_LAT-1] | force_vld;
    assign mem_rdata = force_vld ? 16'hDEAD : mem_word(addr_pipe[MEM_LAT-1]);

    // Reference: the k-th word of a block fill, as an address and as a word index.
    function automatic logic [2:0] exp_word(input logic [15:0] a, input int k);
        int s;
`ifdef CRIT_WORD_FIRST_EN
        s = int'(a[3:1]);
`else
        s = 0;
`endif
        return 3'((s + k) % WORDS);
    endfunction

    function automatic logic [15:0] exp_addr(input logic [15:0] a, input int k);
        return (a & 16'hFFF0) + 16'(2 * int'(exp_word(a, k)));
    endfunction

    // Event capture
    typedef struct { int cyc; logic [15:0] addr; } iss_t;
    typedef struct { int cyc; logic [15:0] addr; logic [15:0] data; } wr_t;
    typedef struct {
        int cyc; logic iwe; logic dwe; logic imeta; logic dmeta; logic [2:0] word; logic [15:0] data;
    } fill_t;

    iss_t  iss_q[$];
    wr_t   wr_q[$];
    fill_t fill_q[$];
    int    cyc = 0;
    int    first_iss, meta_cyc;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (mem_en && !mem_we) iss_q.push_back('{cyc: cyc, addr: mem_addr});
            if (mem_en && mem_we)  wr_q.push_back('{cyc: cyc, addr: mem_addr, data: mem_wdata});
            if (i_data_we || d_data_we || i_meta_we || d_meta_we)
                fill_q.push_back('{cyc: cyc, iwe: i_data_we, dwe: d_data_we, imeta: i_meta_we,
                                   dmeta: d_meta_we, word: fill_word, data: fill_data});
        end
    end

    task automatic score_fill(input bit is_d, input logic [15:0] a, input string name);
        iss_t       e;
        fill_t      f;
        logic [3:0] exp_flags;
        n_cmp++;
        if (iss_q.size() < WORDS || fill_q.size() < WORDS) begin
            n_bad++;
            $display("FAIL %s_count: issued=%0d returned=%0d, required %0d each",
                     name, iss_q.size(), fill_q.size(), WORDS);
            iss_q.delete();
            fill_q.delete();
            first_iss = -100;
            meta_cyc  = -100;
            return;
        end
        first_iss = iss_q[0].cyc;
        meta_cyc  = fill_q[WORDS-1].cyc;
        n_cmp++;
        if (iss_q[WORDS-1].cyc - first_iss != WORDS - 1) begin
            n_bad++;
            $display("FAIL %s_issue_span: %0d cycles, required %0d", name,
                     iss_q[WORDS-1].cyc - first_iss, WORDS - 1);
        end
        n_cmp++;
        if (meta_cyc - first_iss != WORDS + MEM_LAT - 1) begin
            n_bad++;
            $display("FAIL %s_latency: last return %0d cycles after first issue, required %0d",
                     name, meta_cyc - first_iss, WORDS + MEM_LAT - 1);
        end
        for (int k = 0; k < WORDS; k++) begin
            e = iss_q.pop_front();
            f = fill_q.pop_front();
            n_cmp++;
            if (e.addr !== exp_addr(a, k)) begin
                n_bad++;
                $display("FAIL %s_addr[%0d]: got %h, required %h", name, k, e.addr, exp_addr(a, k));
            end
            exp_flags = {~is_d, is_d, ~is_d & (k == WORDS - 1), is_d & (k == WORDS - 1)};
            n_cmp++;
            if ({f.iwe, f.dwe, f.imeta, f.dmeta} !== exp_flags || f.word !== exp_word(a, k)
                || f.data !== mem_word(exp_addr(a, k))) begin
                n_bad++;
                $display("FAIL %s_fill[%0d]: we/meta(i,d)=%b word=%0d data=%h, required %b word=%0d data=%h",
                         name, k, {f.iwe, f.dwe, f.imeta, f.dmeta}, f.word, f.data,
                         exp_flags, exp_word(a, k), mem_word(exp_addr(a, k)));
            end
        end
    endtask

    // Wait for the target's metadata write, drop the served miss in DONE, then score the fill.
    task automatic finish_miss(input bit is_d, input logic [15:0] a, input string name);
        int found = 0;
        int low   = 0;
        for (int i = 0; i < 64 && found == 0; i++) begin
            @(negedge clk);
            if (stall !== 1'b1) low++;
            if ((is_d ? d_meta_we : i_meta_we) === 1'b1) found = 1;
        end
        n_cmp++;
        if (found == 0) begin
            n_bad++;
            $display("FAIL %s_timeout: meta_we seen=%0d, required 1", name, found);
        end
        n_cmp++;
        if (low != 0) begin
            n_bad++;
            $display("FAIL %s_stall: low in %0d fill cycles, required 0", name, low);
        end
        @(posedge clk);
        #1;
        if (is_d) d_miss = 1'b0;
        else      i_miss = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b1 || mem_en !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_done: stall=%b mem_en=%b, required 1 0", name, stall, mem_en);
        end
        score_fill(is_d, a, name);
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b0 || mem_en !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_idle: stall=%b mem_en=%b, required 0 0", name, stall, mem_en);
        end
    endtask

    task automatic run_miss(input bit is_d, input logic [15:0] a, input string name);
        @(posedge clk);
        #1;
        if (is_d) begin d_addr = a; d_miss = 1'b1; end
        else      begin i_addr = a; i_miss = 1'b1; end
        finish_miss(is_d, a, name);
        check_idle(name);
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        i_miss = 1'b1;
        i_addr = 16'h1236;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({mem_en, mem_we, i_data_we, i_meta_we, d_data_we, d_meta_we} !== 6'b0
                || mem_addr !== 16'h0 || mem_wdata !== 16'h0 || fill_word !== 3'd0) begin
                n_bad++;
                $display("FAIL reset_outputs: en/we/i_we/i_meta/d_we/d_meta=%b addr=%h wdata=%h word=%0d, required all 0",
                         {mem_en, mem_we, i_data_we, i_meta_we, d_data_we, d_meta_we},
                         mem_addr, mem_wdata, fill_word);
            end
            n_cmp++;
            if (stall !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_stall: stall=%b with i_miss pending, required 1", stall);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_en !== 1'b1 || mem_addr !== exp_addr(16'h1236, 0)) begin
            n_bad++;
            $display("FAIL reset_first_issue: mem_en=%b addr=%h, required 1 %h",
                     mem_en, mem_addr, exp_addr(16'h1236, 0));
        end
        finish_miss(1'b0, 16'h1236, "reset_i");
        check_idle("reset_i");
    endtask

    task automatic test_i_miss();
        run_miss(1'b0, 16'h1236, "i_miss_1236");
`ifdef CRIT_WORD_FIRST_EN
        run_miss(1'b0, 16'h123A, "i_miss_123a");
`endif
        for (int n = 0; n < 3; n++) run_miss(1'b0, 16'($urandom), "i_miss_rand");
    endtask

    task automatic test_d_miss();
        for (int n = 0; n < 3; n++) run_miss(1'b1, 16'($urandom), "d_miss_rand");
    endtask

    task automatic test_dual_miss();
        logic [15:0] da, ia;
        for (int n = 0; n < 3; n++) begin
            da = (n == 0) ? 16'h4008 : 16'($urandom);
            ia = (n == 0) ? 16'h0100 : 16'($urandom);
            @(posedge clk);
            #1;
            d_addr = da; i_addr = ia; d_miss = 1'b1; i_miss = 1'b1;
            finish_miss(1'b1, da, "dual_d");
            begin
                int d_meta = meta_cyc;
                finish_miss(1'b0, ia, "dual_i");
                n_cmp++;
                if (first_iss - d_meta != 3) begin
                    n_bad++;
                    $display("FAIL dual_gap: I fill issued %0d cycles after D last return, required 3",
                             first_iss - d_meta);
                end
            end
            check_idle("dual");
        end
    endtask

    task automatic test_write_during_fill();
        logic [15:0] ia;
        ia = 16'($urandom);
        @(posedge clk);
        #1;
        i_addr = ia; i_miss = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        d_addr = 16'h2002; d_wdata = 16'hBEEF; d_wr = 1'b1;
        finish_miss(1'b0, ia, "wr_fill");
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b1 || mem_en !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_fill_idle: stall=%b mem_en=%b, required 1 0", stall, mem_en);
        end
        @(negedge clk);
        n_cmp++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h2002
            || mem_wdata !== 16'hBEEF || stall !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_fill_store: en=%b we=%b addr=%h data=%h stall=%b, required 1 1 2002 beef 0",
                     mem_en, mem_we, mem_addr, mem_wdata, stall);
        end
        @(posedge clk);
        #1;
        d_wr = 1'b0;
        check_idle("wr_fill");
        n_cmp++;
        if (wr_q.size() != 1) begin
            n_bad++;
            $display("FAIL wr_fill_count: %0d stores, required 1", wr_q.size());
        end
        wr_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [15:0] wa, wd;
        int found;
        wr_q.delete();
        @(posedge clk);
        #1;
        wa = 16'($urandom); wd = 16'($urandom);
        d_addr = wa; d_wdata = wd; d_wr = 1'b1;
        for (int n = 0; n < 6; n++) begin
            found = 0;
            for (int i = 0; i < 4 && found == 0; i++) begin
                @(negedge clk);
                if (mem_we === 1'b1) begin
                    found = 1;
                end else begin
                    n_cmp++;
                    if (stall !== 1'b1) begin
                        n_bad++;
                        $display("FAIL b2b_wait_stall: stall=%b with store pending, required 1", stall);
                    end
                end
            end
            n_cmp++;
            if (found == 0 || mem_en !== 1'b1 || mem_addr !== wa || mem_wdata !== wd || stall !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_store[%0d]: seen=%0d en=%b addr=%h data=%h stall=%b, required 1 1 %h %h 0",
                         n, found, mem_en, mem_addr, mem_wdata, stall, wa, wd);
            end
            @(posedge clk);
            #1;
            if (n == 5) begin
                d_wr = 1'b0;
            end else begin
                wa = 16'($urandom); wd = 16'($urandom);
                d_addr = wa; d_wdata = wd;
            end
        end
        check_idle("b2b");
        n_cmp++;
        if (wr_q.size() != 6) begin
            n_bad++;
            $display("FAIL b2b_count: %0d stores, required 6", wr_q.size());
        end else begin
            for (int n = 1; n < 6; n++) begin
                n_cmp++;
                if (wr_q[n].cyc - wr_q[n-1].cyc != 2) begin
                    n_bad++;
                    $display("FAIL b2b_spacing[%0d]: %0d cycles, required 2", n, wr_q[n].cyc - wr_q[n-1].cyc);
                end
            end
        end
        wr_q.delete();
    endtask

    task automatic test_reset_mid_fill();
        logic [15:0] da;
        int issues = 0;
        int bad    = 0;
        da = 16'($urandom);
        @(posedge clk);
        #1;
        d_addr = da; d_miss = 1'b1;
        for (int i = 0; i < 20 && issues < 5; i++) begin
            @(negedge clk);
            if (mem_en === 1'b1) issues++;
        end
        n_cmp++;
        if (issues != 5) begin
            n_bad++;
            $display("FAIL rst_mid_issue: %0d issue cycles seen, required 5", issues);
        end
        rst    = 1'b1;
        d_miss = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (mem_en !== 1'b0 || d_meta_we !== 1'b0 || d_data_we !== 1'b0 || i_data_we !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL rst_mid_quiet: %0d cycles with mem_en or a write enable after reset, required 0", bad);
        end
        iss_q.delete();
        fill_q.delete();
        run_miss(1'b1, da, "rst_mid_refill");
    endtask

    task automatic test_stray_vld();
        int bad = 0;
        @(posedge clk);
        #1;
        force_vld = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if ({i_data_we, i_meta_we, d_data_we, d_meta_we} !== 4'b0 || fill_word !== 3'd0) bad++;
        end
        force_vld = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL stray_vld: %0d idle cycles with a cache write, required 0", bad);
        end
    endtask

    initial begin
        mem_seed  = 16'($urandom);
        force_vld = 1'b0;
        rst       = 1'b1;
        i_miss    = 1'b0;
        d_miss    = 1'b0;
        d_wr      = 1'b0;
        i_addr    = '0;
        d_addr    = '0;
        d_wdata   = '0;
        test_reset();
        test_i_miss();
        test_d_miss();
        test_dual_miss();
        test_write_during_fill();
        test_back_to_back();
        test_reset_mid_fill();
        test_stray_vld();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
